irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt controller sitting directly upstream of the processor's irq_i/eoi_o pair.
//  Collects NUM_SRC peripheral interrupt sources and routes each to one of two CPU lines.
//  Resolves priority per line and runs the raise/take/EOI handshake.
//  Software programs it and reads the claimed source ID through a memory-mapped slave port on the same sel/ack bus.
// PARAMETERS
//  NUM_SRC  8  number of interrupt sources, 1..32; source 0 has the highest priority
// PORTS
//  clk        in   1        system clock
//  reset_i    in   1        asynchronous, active-high reset
//  src_i      in   NUM_SRC  raw interrupt sources, asynchronous to clk
//  irq_o      out  2        interrupt request to processor irq_i
//  eoi_i      in   2        processor eoi_o; 1=idle, 0=line taken, back to 1 = end of interrupt
//  sel_i      in   1        slave select, held until ack_o
//  addr_i     in   32       byte address; only [4:2] decoded
//  we_i       in   1        write enable
//  wr_mask_i  in   4        byte write mask
//  data_i     in   32       write data
//  data_o     out  32       read data, valid while ack_o=1
//  ack_o      out  1        one-cycle transfer acknowledge
// BEHAVIOUR
//  Reset (async): irq_o=0, ack_o=0, data_o=0; ENABLE, MODE, TARGET, pending and synchronizers=0; both line FSMs IDLE; claims invalid.
//  Sources: 2-flop synchronizer per bit; edge sources use a rising-edge detect on the synced value.
//  Register map, addr_i[4:2] (bits >= NUM_SRC read 0, writes ignored):
//   0 ENABLE   RW  per-source enable
//   1 MODE     RW  1=edge (latched pending), 0=level
//   2 TARGET   RW  0=route to line 0, 1=route to line 1
//   3 PENDING  R: level bits = synced src; edge bits = latch. W1C on edge bits only
//   4 CLAIM0   R  {valid[31], 26'b0, id[4:0]} of line 0 in-service/asserted source
//   5 CLAIM1   R  same for line 1; addresses 6,7 read 0, writes ignored
//  Writes honour wr_mask_i per byte.
//  Edge latch set and W1C in the same cycle: set wins.
//  Disabled sources still latch edge pending; they are not eligible.
//  Bus: when sel_i=1 and ack_o=0, perform the access and register ack_o=1 for one cycle (latency 1). ack_o is then 0 for at least one cycle.
//  eligible_n = pending & ENABLE & (TARGET==n).
//  Line n FSM:
//   IDLE:    if eligible_n!=0, latch id = lowest set bit, claim valid, then ASSERT with irq_o[n]=1 next cycle.
//   ASSERT:  hold irq_o[n]=1 and keep id fixed even if higher-priority sources arrive; on eoi_i[n]==0 go to SERVICE with irq_o[n]=0.
//   SERVICE: irq_o[n]=0; on eoi_i[n]==1, clear the id's edge pending bit (level bits are not touched), invalidate the claim, then IDLE.
//  irq_o[n] is low for at least one cycle between interrupts, covering the processor's release cycle.
//  Source disabled or retargeted while in ASSERT: the request still completes; no retraction.
//  Level source deasserted in ASSERT: same, the claim stays.
//  Both lines are independent and can be pending together; the processor serialises them.
//  eoi_i[n]=0 while the line is in IDLE is ignored.
//  Reset mid-handshake: returns to IDLE at once and irq_o drops asynchronously.
// TESTING
//  1 Reset -> irq_o=00, ack_o=0; read ENABLE/MODE/TARGET -> 0; bus read ack arrives exactly 1 cycle after sel_i.
//  2 ENABLE=0x01, MODE=0x01, pulse src_i[0] -> PENDING=0x01, irq_o=01 within 4 cycles, CLAIM0=0x80000000;
//    eoi 1->0->1 -> PENDING=0, irq_o stays 00.
//  3 ENABLE=0x0C, TARGET=0x08, level src 2 and 3 high -> irq_o=11; CLAIM0 id=2; CLAIM1 id=3.
//  4 ENABLE=0x06, edges on src 2 then src 1 while line 0 in ASSERT -> CLAIM0 stays 2;
//    after EOI, irq_o[0] low >=1 cycle, then re-asserts with id=1.
//  5 Edge on src 5 in the same cycle as a W1C write 0x20 to PENDING -> PENDING bit 5 remains 1.
//  6 Assert reset_i while in SERVICE -> irq_o=00 immediately; claims invalid;
//    a level source still high re-raises its line after reset is released.

Source files
------------

// File: rtl/irq_controller.sv
// Two-line interrupt controller: synchronises sources, latches edges, arbitrates by lowest ID
// and runs the raise/take/EOI handshake per CPU line, with a sel/ack register slave port.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [1:0]         irq_o,
  input  logic [1:0]         eoi_i,
  input  logic               sel_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         wr_mask_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               ack_o
);

  localparam int unsigned IdW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } line_state_e;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] en_q, en_d, mode_q, mode_d, tgt_q, tgt_d, latch_q, latch_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;

  line_state_e [1:0]          state_q, state_d;
  logic        [1:0][IdW-1:0] id_q, id_d;
  logic        [1:0]          valid_q, valid_d;
  logic        [1:0]          irq_q, irq_d;

  logic [NUM_SRC-1:0]         pending, wmask, wdata, w1c, eoi_clr;
  logic [1:0][NUM_SRC-1:0]    elig;
  logic [31:0]                byte_mask, rmux;
  logic                       access;

  function automatic logic [IdW-1:0] lowest(input logic [NUM_SRC-1:0] v);
    lowest = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (v[i]) lowest = IdW'(i);
    end
  endfunction

  assign irq_o  = irq_q;
  assign ack_o  = ack_q;
  assign data_o = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{addr_i[31:5], addr_i[1:0], data_i, byte_mask};

  // Register file, pending view and bus access
  always_comb begin
    pending   = (mode_q & latch_q) | (~mode_q & sync2_q);
    elig[0]   = pending & en_q & ~tgt_q;
    elig[1]   = pending & en_q & tgt_q;
    byte_mask = {{8{wr_mask_i[3]}}, {8{wr_mask_i[2]}}, {8{wr_mask_i[1]}}, {8{wr_mask_i[0]}}};
    wmask     = byte_mask[NUM_SRC-1:0];
    wdata     = data_i[NUM_SRC-1:0];
    access    = sel_i & ~ack_q;
    en_d      = en_q;
    mode_d    = mode_q;
    tgt_d     = tgt_q;
    w1c       = '0;
    rmux      = '0;
    ack_d     = access;
    case (addr_i[4:2])
      3'd0:    rmux = 32'(en_q);
      3'd1:    rmux = 32'(mode_q);
      3'd2:    rmux = 32'(tgt_q);
      3'd3:    rmux = 32'(pending);
      3'd4:    rmux = {valid_q[0], 26'b0, id_q[0]};
      3'd5:    rmux = {valid_q[1], 26'b0, id_q[1]};
      default: rmux = '0;
    endcase
    rdata_d = (access && !we_i) ? rmux : 32'h0;
    if (access && we_i) begin
      case (addr_i[4:2])
        3'd0:    en_d   = (en_q & ~wmask) | (wdata & wmask);
        3'd1:    mode_d = (mode_q & ~wmask) | (wdata & wmask);
        3'd2:    tgt_d  = (tgt_q & ~wmask) | (wdata & wmask);
        3'd3:    w1c    = wdata & wmask & mode_q;
        default: ;
      endcase
    end
    // A fresh edge beats any clear landing in the same cycle
    latch_d = (latch_q & ~(w1c | eoi_clr)) | (mode_q & sync2_q & ~prev_q);
  end

  // Per-line raise/take/EOI handshake
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    valid_d = valid_q;
    irq_d   = 2'b00;
    eoi_clr = '0;
    for (int n = 0; n < 2; n++) begin
      case (state_q[n])
        IDLE: begin
          if (|elig[n]) begin
            id_d[n]    = lowest(elig[n]);
            valid_d[n] = 1'b1;
            irq_d[n]   = 1'b1;
            state_d[n] = ASSERT;
          end
        end
        ASSERT: begin
          if (!eoi_i[n]) state_d[n] = SERVICE;
          else           irq_d[n]   = 1'b1;
        end
        SERVICE: begin
          if (eoi_i[n]) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
              if (IdW'(i) == id_q[n]) eoi_clr[i] = 1'b1;
            end
            id_d[n]    = '0;
            valid_d[n] = 1'b0;
            state_d[n] = IDLE;
          end
        end
        default: state_d[n] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      tgt_q   <= '0;
      latch_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      state_q <= {IDLE, IDLE};
      id_q    <= '0;
      valid_q <= '0;
      irq_q   <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      en_q    <= en_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed literal scenarios plus randomized traffic, with a
// cycle-level behavioural model compared against the DUT on every falling edge.
module tb_irq_controller;

  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [N-1:0]  src_i;
  logic [1:0]    irq_o;
  logic [1:0]    eoi_i;
  logic          sel_i;
  logic [31:0]   addr_i;
  logic          we_i;
  logic [3:0]    wr_mask_i;
  logic [31:0]   data_i;
  logic [31:0]   data_o;
  logic          ack_o;

  int checks = 0;
  int passed = 0;

  irq_controller #(.NUM_SRC(N)) dut (
    .clk(clk), .reset_i(reset_i), .src_i(src_i), .irq_o(irq_o), .eoi_i(eoi_i),
    .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i), .wr_mask_i(wr_mask_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_s1, m_s2, m_prev, m_en, m_mode, m_tgt, m_latch;
  logic [N-1:0] pend, set_v, clr, elg, wm;
  int           m_phase [2];   // 0 waiting, 1 raised, 2 taken by CPU
  int           m_id [2];
  bit           m_valid [2];
  logic [1:0]   m_irq;
  bit           m_ack;
  logic [31:0]  m_data;

  function automatic logic [31:0] claim_word(input bit v, input int id);
    return v ? (32'h8000_0000 | 32'(id)) : 32'h0;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_en = '0; m_mode = '0; m_tgt = '0; m_latch = '0;
      for (int n = 0; n < 2; n++) begin m_phase[n] = 0; m_id[n] = 0; m_valid[n] = 0; end
      m_irq = 2'b00; m_ack = 0; m_data = '0;
    end else begin
      pend  = (m_mode & m_latch) | (~m_mode & m_s2);
      set_v = m_mode & m_s2 & ~m_prev;
      m_data = '0;
      if (sel_i && !m_ack && !we_i) begin
        case (int'(addr_i[4:2]))
          0: m_data = 32'(m_en);
          1: m_data = 32'(m_mode);
          2: m_data = 32'(m_tgt);
          3: m_data = 32'(pend);
          4: m_data = claim_word(m_valid[0], m_id[0]);
          5: m_data = claim_word(m_valid[1], m_id[1]);
          default: m_data = '0;
        endcase
      end
      clr = '0;
      for (int n = 0; n < 2; n++) begin
        elg = pend & m_en & ((n == 1) ? m_tgt : ~m_tgt);
        if (m_phase[n] == 0 && elg != 0) begin
          for (int i = N - 1; i >= 0; i--) if (elg[i]) m_id[n] = i;
          m_valid[n] = 1; m_phase[n] = 1;
        end else if (m_phase[n] == 1 && !eoi_i[n]) begin
          m_phase[n] = 2;
        end else if (m_phase[n] == 2 && eoi_i[n]) begin
          clr[m_id[n]] = 1'b1; m_valid[n] = 0; m_phase[n] = 0;
        end
      end
      if (sel_i && !m_ack && we_i) begin
        for (int b = 0; b < N; b++) wm[b] = wr_mask_i[b / 8];
        case (int'(addr_i[4:2]))
          0: m_en   = (m_en & ~wm) | (data_i[N-1:0] & wm);
          1: m_mode = (m_mode & ~wm) | (data_i[N-1:0] & wm);
          2: m_tgt  = (m_tgt & ~wm) | (data_i[N-1:0] & wm);
          3: clr    = clr | (data_i[N-1:0] & wm & m_mode);
          default: ;
        endcase
      end
      m_latch = (m_latch & ~clr) | set_v;
      m_ack   = sel_i && !m_ack;
      m_prev  = m_s2; m_s2 = m_s1; m_s1 = src_i;
      for (int n = 0; n < 2; n++) m_irq[n] = (m_phase[n] == 1);
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("model_irq", 32'(irq_o), 32'(m_irq));
      chk("model_ack", 32'(ack_o), 32'(m_ack));
      if (m_ack) chk("model_rdata", data_o, m_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus(input int r, input bit we, input logic [3:0] m, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    addr_i = {27'($urandom), 3'(r), 2'($urandom)};
    sel_i = 1'b1; we_i = we; wr_mask_i = m; data_i = wd; lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); lat++;
      if (ack_o) break;
    end
    chk("bus_ack", 32'(ack_o), 32'h1);
    rd = data_o;
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input int r, input logic [31:0] v);
    logic [31:0] d; int l;
    bus(r, 1'b1, 4'hF, v, d, l);
  endtask

  task automatic rd_chk(input string name, input int r, input logic [31:0] exp);
    logic [31:0] d; int l;
    bus(r, 1'b0, 4'hF, 32'h0, d, l);
    chk(name, d, exp);
  endtask

  task automatic wait_irq(input int n, input string name);
    for (int k = 0; k < 12 && !irq_o[n]; k++) tick();
    chk(name, 32'(irq_o[n]), 32'h1);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    reset_i = 1'b1; src_i = '0; eoi_i = 2'b11; sel_i = 1'b0; addr_i = '0;
    we_i = 1'b0; wr_mask_i = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_data", data_o, 32'h0);
    reset_i = 1'b0;
    tick();

    // Reset values and one-cycle ack latency
    bus(0, 1'b0, 4'hF, 32'h0, d, lat);
    chk("enable_rst", d, 32'h0);
    chk("ack_latency", 32'(lat), 32'h1);
    rd_chk("mode_rst", 1, 32'h0);
    rd_chk("target_rst", 2, 32'h0);

    // Edge source 0 through the whole handshake
    wr(0, 32'h01); wr(1, 32'h01);
    src_i[0] = 1'b1; tick(); src_i[0] = 1'b0;
    wait_irq(0, "t2_irq");
    chk("t2_irq_vec", 32'(irq_o), 32'h1);
    rd_chk("t2_pending", 3, 32'h01);
    rd_chk("t2_claim0", 4, 32'h8000_0000);
    eoi_i[0] = 1'b0; tick(); tick(); eoi_i[0] = 1'b1;
    tick(); tick();
    rd_chk("t2_pending_clr", 3, 32'h0);
    chk("t2_irq_low", 32'(irq_o), 32'h0);
    rd_chk("t2_claim_inv", 4, 32'h0);

    // Level sources split across both lines
    wr(1, 32'h00); wr(2, 32'h08); wr(0, 32'h0C);
    src_i[3:2] = 2'b11;
    wait_irq(0, "t3_irq0");
    wait_irq(1, "t3_irq1");
    chk("t3_irq_vec", 32'(irq_o), 32'h3);
    rd_chk("t3_claim0", 4, 32'h8000_0002);
    rd_chk("t3_claim1", 5, 32'h8000_0003);
    src_i = '0; eoi_i = 2'b00; tick(); tick(); eoi_i = 2'b11;
    repeat (3) tick();
    chk("t3_irq_done", 32'(irq_o), 32'h0);

    // Claim stays fixed while a higher-priority edge arrives
    wr(2, 32'h00); wr(1, 32'h06); wr(0, 32'h06);
    src_i[2] = 1'b1; tick(); src_i[2] = 1'b0;
    wait_irq(0, "t4_irq");
    src_i[1] = 1'b1; tick(); src_i[1] = 1'b0;
    repeat (5) tick();
    rd_chk("t4_claim_fixed", 4, 32'h8000_0002);
    eoi_i[0] = 1'b0; tick(); eoi_i[0] = 1'b1; tick();
    chk("t4_irq_gap", 32'(irq_o[0]), 32'h0);
    wait_irq(0, "t4_reraise");
    rd_chk("t4_claim_next", 4, 32'h8000_0001);
    eoi_i[0] = 1'b0; tick(); eoi_i[0] = 1'b1;
    repeat (3) tick();
    rd_chk("t4_pending_clr", 3, 32'h0);

    // Edge set collides with W1C: set wins
    wr(0, 32'h00); wr(1, 32'h20);
    src_i[5] = 1'b1; tick(); tick();
    wr(3, 32'h20);
    rd_chk("t5_set_wins", 3, 32'h20);
    wr(3, 32'h20);
    rd_chk("t5_w1c", 3, 32'h0);
    src_i[5] = 1'b0;

    // Reset in the middle of SERVICE
    wr(1, 32'h00); wr(0, 32'h10);
    src_i[4] = 1'b1;
    wait_irq(0, "t6_irq");
    eoi_i[0] = 1'b0; tick(); tick();
    reset_i = 1'b1; #1;
    chk("t6_irq_async", 32'(irq_o), 32'h0);
    eoi_i[0] = 1'b1; tick(); tick();
    reset_i = 1'b0; tick();
    rd_chk("t6_claim_inv", 4, 32'h0);
    wr(0, 32'h10);
    wait_irq(0, "t6_reraise");
    rd_chk("t6_claim", 4, 32'h8000_0004);
    src_i = '0; eoi_i[0] = 1'b0; tick(); eoi_i[0] = 1'b1;
    repeat (3) tick();

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      src_i = src_i ^ (N'($urandom) & N'($urandom) & N'($urandom));
      for (int n = 0; n < 2; n++) if ($urandom_range(0, 3) == 0) eoi_i[n] = ~eoi_i[n];
      if (sel_i && ack_o) begin
        sel_i = 1'b0; we_i = 1'b0;
      end else if (!sel_i && $urandom_range(0, 2) == 0) begin
        we_i      = 1'($urandom);
        addr_i    = {27'($urandom), we_i ? 3'($urandom_range(0, 3)) : 3'($urandom), 2'($urandom)};
        wr_mask_i = 4'($urandom);
        data_i    = $urandom;
        sel_i     = 1'b1;
      end
      if (c == 1500) begin
        reset_i = 1'b1; tick(); reset_i = 1'b0; sel_i = 1'b0;
      end
      tick();
    end
    sel_i = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
